// File: rtl/mandala_palette_stage.sv
// Palette/output stage for the mandala generator: ring index -> 2-bit RGB, per-frame palette
// animation FSM, and a matched-latency pipeline onto the TinyVGA PMOD pinout.
// Optional build macro: MANDALA_BG_GLOW_EN (dim complementary background on active, unlit pixels).
module mandala_palette_stage #(
    parameter int PIPE_DEPTH = 2,
    parameter int FRAME_DIV  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       video_active_in,
    input  logic       pattern_in,
    input  logic [2:0] layer_in,
    input  logic [1:0] mode_in,
    output logic [7:0] uo_out,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ST_CYCLE   = 2'b00,
        ST_HOLD    = 2'b01,
        ST_REVERSE = 2'b10,
        ST_STROBE  = 2'b11
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    state_t     state_reg, state_next;
    logic [2:0] offset_reg, offset_next;
    logic [7:0] div_cnt_reg, div_cnt_next;
    logic       strobe_vis_reg, strobe_vis_next;
    logic       vsync_prev_reg;
    logic       vsync_armed_reg;
    logic       frame_event;
    logic       strobe_vis_eff;
    logic       lit;
    logic [2:0] colour_idx;
    logic [5:0] colour;
    logic [8:0] stage0_next;

    function automatic logic [5:0] palette(input logic [2:0] idx);
        logic [5:0] entry;
        case (idx)
            3'd0:    entry = 6'b110000;
            3'd1:    entry = 6'b111000;
            3'd2:    entry = 6'b111100;
            3'd3:    entry = 6'b001100;
            3'd4:    entry = 6'b001111;
            3'd5:    entry = 6'b000011;
            3'd6:    entry = 6'b100011;
            default: entry = 6'b111111;
        endcase
        return entry;
    endfunction

    // The armed flag keeps a vsync that is already high at reset release from counting as an edge.
    assign frame_event = vsync_in & ~vsync_prev_reg & vsync_armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_reg  <= 1'b0;
            vsync_armed_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (!vsync_in) begin
                vsync_armed_reg <= 1'b1;
            end
        end
    end

    // FSM state and animation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_CYCLE;
            offset_reg     <= 3'd0;
            div_cnt_reg    <= 8'd0;
            strobe_vis_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            offset_reg     <= offset_next;
            div_cnt_reg    <= div_cnt_next;
            strobe_vis_reg <= strobe_vis_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (frame_event) begin
            state_next = state_t'(mode_in);
        end
    end

    // A mode change takes priority over a coinciding divider wrap: counter clears, no step.
    always_comb begin
        offset_next     = offset_reg;
        div_cnt_next    = div_cnt_reg;
        strobe_vis_next = strobe_vis_reg;
        if (frame_event) begin
            if (state_next != state_reg) begin
                div_cnt_next    = 8'd0;
                strobe_vis_next = 1'b1;
            end else if (div_cnt_reg >= DIV_LAST) begin
                div_cnt_next = 8'd0;
                case (state_reg)
                    ST_CYCLE:   offset_next = offset_reg + 3'd1;
                    ST_REVERSE: offset_next = offset_reg - 3'd1;
                    ST_STROBE: begin
                        offset_next     = offset_reg + 3'd1;
                        strobe_vis_next = ~strobe_vis_reg;
                    end
                    default:    offset_next = offset_reg;
                endcase
            end else begin
                div_cnt_next = div_cnt_reg + 8'd1;
            end
        end
    end

    assign strobe_vis_eff = (state_reg != ST_STROBE) | strobe_vis_reg;
    assign colour_idx     = layer_in + offset_reg;
    assign lit            = video_active_in & pattern_in & strobe_vis_eff;

`ifdef MANDALA_BG_GLOW_EN
    logic [5:0] glow_entry;
    logic [2:0] glow_idx;

    assign glow_idx   = offset_reg + 3'd4;
    assign glow_entry = palette(glow_idx);

    always_comb begin
        colour = 6'b000000;
        if (lit) begin
            colour = palette(colour_idx);
        end else if (video_active_in) begin
            colour = {1'b0, glow_entry[5], 1'b0, glow_entry[3], 1'b0, glow_entry[1]};
        end
    end
`else
    always_comb begin
        colour = 6'b000000;
        if (lit) begin
            colour = palette(colour_idx);
        end
    end
`endif

    // colour is {R1,R0,G1,G0,B1,B0}; pack as {frame_tick, hsync,B0,G0,R0, vsync,B1,G1,R1}
    assign stage0_next = {frame_event,
                          hsync_in, colour[0], colour[2], colour[4],
                          vsync_in, colour[1], colour[3], colour[5]};

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
            logic [8:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= 9'd0;
                    end else begin
                        stage_reg <= stage0_next;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= 9'd0;
                    end else begin
                        stage_reg <= g_pipe[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign {frame_tick, uo_out} = g_pipe[PIPE_DEPTH-1].stage_reg;

endmodule

// File: tb/tb_mandala_palette_stage.sv
// Directed bench for mandala_palette_stage (PIPE_DEPTH=2, FRAME_DIV=8); expectations are
// hand-packed TinyVGA bytes. Honours MANDALA_BG_GLOW_EN for the unlit-pixel cases.
module tb_mandala_palette_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_in;
    logic       vsync_in;
    logic       video_active_in;
    logic       pattern_in;
    logic [2:0] layer_in;
    logic [1:0] mode_in;
    logic [7:0] uo_out;
    logic       frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    // Palette entries packed onto uo_out with both syncs low
    logic [7:0] pal_uo [8] = '{8'h11, 8'h13, 8'h33, 8'h22, 8'h66, 8'h44, 8'h45, 8'h77};

`ifdef MANDALA_BG_GLOW_EN
    localparam logic [7:0] UNLIT_OFS0 = 8'h60;
`else
    localparam logic [7:0] UNLIT_OFS0 = 8'h00;
`endif

    mandala_palette_stage #(
        .PIPE_DEPTH(2),
        .FRAME_DIV (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .video_active_in(video_active_in),
        .pattern_in     (pattern_in),
        .layer_in       (layer_in),
        .mode_in        (mode_in),
        .uo_out         (uo_out),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp_uo, input logic exp_tick);
        vectors++;
        assert ({frame_tick, uo_out} === {exp_tick, exp_uo}) else begin
            miscompares++;
            $error("FAIL %s: uo_out=%h frame_tick=%b, expected uo_out=%h frame_tick=%b",
                   tag, uo_out, frame_tick, exp_uo, exp_tick);
        end
        $display("vec %0d %s: uo_out=%h frame_tick=%b", vectors, tag, uo_out, frame_tick);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle vsync pulse; returns once a pixel entered after the update has reached uo_out.
    task automatic frames(input int n);
        repeat (n) begin
            vsync_in = 1'b1;
            @(negedge clk);
            vsync_in = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        hsync_in        = 1'b1;
        vsync_in        = 1'b0;
        video_active_in = 1'b1;
        pattern_in      = 1'b1;
        layer_in        = 3'd2;
        mode_in         = 2'b00;
        ticks(3);
        check("reset_hold", 8'h00, 1'b0);

        rst_n = 1'b1;
        ticks(1);
        check("release_cycle1", 8'h00, 1'b0);
        ticks(1);
        check("release_yellow", 8'hB3, 1'b0);

        hsync_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            layer_in = 3'(i);
            ticks(2);
            check($sformatf("layer%0d_ofs0", i), pal_uo[i], 1'b0);
        end

        layer_in   = 3'd0;
        pattern_in = 1'b0;
        ticks(2);
        check("unlit_active", UNLIT_OFS0, 1'b0);
        pattern_in      = 1'b1;
        video_active_in = 1'b0;
        ticks(2);
        check("blanked", 8'h00, 1'b0);
        video_active_in = 1'b1;

        // Frame 1 done by hand to see frame_tick aligned with the vsync bit
        vsync_in = 1'b1;
        ticks(1);
        vsync_in = 1'b0;
        ticks(1);
        check("tick_pulse", 8'h19, 1'b1);
        ticks(1);
        check("tick_single", 8'h11, 1'b0);

        frames(6);
        check("cycle_frame7", pal_uo[0], 1'b0);
        frames(1);
        check("cycle_frame8", pal_uo[1], 1'b0);
        frames(48);
        check("cycle_frame56", pal_uo[7], 1'b0);
        frames(8);
        check("cycle_wrap64", pal_uo[0], 1'b0);

        mode_in = 2'b10;
        frames(1);
        check("rev_change", pal_uo[0], 1'b0);
        frames(7);
        check("rev_frame7", pal_uo[0], 1'b0);
        frames(1);
        check("rev_step_white", 8'h77, 1'b0);

        mode_in = 2'b01;
        frames(8);
        check("hold_8frames", pal_uo[7], 1'b0);

        // div_cnt is at 7 here: the mode change must win over the wrap
        mode_in = 2'b11;
        frames(1);
        check("strobe_enter", pal_uo[7], 1'b0);
        frames(7);
        check("strobe_frame7", pal_uo[7], 1'b0);
        frames(1);
        check("strobe_dark", UNLIT_OFS0, 1'b0);
        frames(8);
        check("strobe_lit", pal_uo[1], 1'b0);

        mode_in  = 2'b00;
        vsync_in = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        ticks(1);
        check("rerelease_cycle1", 8'h00, 1'b0);
        ticks(1);
        check("vsync_high_no_tick_a", 8'h19, 1'b0);
        ticks(1);
        check("vsync_high_no_tick_b", 8'h19, 1'b0);
        vsync_in = 1'b0;
        ticks(1);
        vsync_in = 1'b1;
        ticks(2);
        check("tick_after_rearm", 8'h19, 1'b1);
        vsync_in = 1'b0;
        ticks(2);
        check("after_rearm_idle", pal_uo[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
